// File: rtl/s_core_boot_seq.sv
// Program-load and run sequencer for the pipelined core.
// Streams imem / regfile preload beats into the core's setup ports, holds the
// core in reset for a settle window, releases it at a programmable start PC,
// then watches the fetch PC for a halt self-loop or a watchdog expiry.
module s_core_boot_seq #(
  parameter int              XLEN          = 32,
  parameter int              IMEM_WORDS    = 64,
  parameter logic [XLEN-1:0] START_ADDR    = 32'h00000004,
  parameter int              SETTLE_CYCLES = 2,
  parameter int              HALT_CYCLES   = 4,
  parameter int              CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_ld_valid,
  output logic             o_ld_ready,
  input  logic             i_ld_kind,
  input  logic [XLEN-1:0]  i_ld_addr,
  input  logic [XLEN-1:0]  i_ld_data,
  input  logic             i_ld_last,
  input  logic [XLEN-1:0]  i_pc_start,
  input  logic [XLEN-1:0]  i_core_pc,
  output logic             o_core_rst_n,
  output logic             o_setup,
  output logic             o_imem_we,
  output logic [XLEN-1:0]  o_inst_mem_addr,
  output logic [XLEN-1:0]  o_inst_mem_data,
  output logic             o_reg_we,
  output logic [4:0]       o_load_reg_addr,
  output logic [XLEN-1:0]  o_load_reg_data,
  output logic [XLEN-1:0]  o_pc_start,
  output logic             o_done,
  output logic             o_timeout,
  output logic             o_overflow,
  output logic [CNT_W-1:0] o_cycles
);

  localparam int IC_W = $clog2(IMEM_WORDS + 1);
  localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
  localparam int HC_W = (HALT_CYCLES > 2) ? $clog2(HALT_CYCLES) : 1;

  localparam logic [IC_W-1:0]  IMEM_MAX    = IC_W'(IMEM_WORDS);
  localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [HC_W-1:0]  HALT_LAST   = HC_W'(HALT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONES    = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_DONE, S_TIMEOUT
  } state_t;

  state_t            state, state_nx;
  logic [IC_W-1:0]   icnt;
  logic [SC_W-1:0]   scnt;
  logic [HC_W-1:0]   hcnt;
  logic [XLEN-1:0]   prev_pc;
  logic              run_first;

  logic              beat;
  logic [HC_W-1:0]   halt_nx;
  logic [CNT_W-1:0]  cyc_nx;
  logic              halt_hit;
  logic              wd_hit;

  // o_ld_ready is high exactly while in LOAD, so it doubles as the beat qualifier
  assign beat     = i_ld_valid & o_ld_ready;
  // first RUN cycle has no valid previous PC, so it always counts as a change
  assign halt_nx  = (run_first || (i_core_pc != prev_pc)) ? '0 : hcnt + 1'b1;
  assign cyc_nx   = (o_cycles == CNT_ONES) ? o_cycles : o_cycles + 1'b1;
  assign halt_hit = (halt_nx == HALT_LAST);
  assign wd_hit   = (cyc_nx == CNT_ONES);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; halt takes priority over watchdog
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_TIMEOUT: if (i_start) state_nx = S_LOAD;
      S_LOAD:   if (beat && i_ld_last) state_nx = S_SETTLE;
      S_SETTLE: if (scnt == SETTLE_LAST) state_nx = S_RUN;
      S_RUN: begin
        if (halt_hit)    state_nx = S_DONE;
        else if (wd_hit) state_nx = S_TIMEOUT;
      end
      default:  state_nx = S_IDLE;
    endcase
  end

  // Registered outputs and datapath, all driven from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ld_ready      <= 1'b0;
      o_setup         <= 1'b0;
      o_core_rst_n    <= 1'b0;
      o_imem_we       <= 1'b0;
      o_inst_mem_addr <= '0;
      o_inst_mem_data <= '0;
      o_reg_we        <= 1'b0;
      o_load_reg_addr <= '0;
      o_load_reg_data <= '0;
      o_pc_start      <= START_ADDR;
      o_done          <= 1'b0;
      o_timeout       <= 1'b0;
      o_overflow      <= 1'b0;
      o_cycles        <= '0;
      icnt            <= '0;
      scnt            <= '0;
      hcnt            <= '0;
      prev_pc         <= '0;
      run_first       <= 1'b0;
    end else begin
      o_ld_ready   <= (state_nx == S_LOAD);
      o_setup      <= (state_nx == S_LOAD);
      o_core_rst_n <= (state_nx == S_RUN);
      o_imem_we    <= 1'b0;
      o_reg_we     <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          if (i_start) begin
            o_done     <= 1'b0;
            o_timeout  <= 1'b0;
            o_overflow <= 1'b0;
            o_cycles   <= '0;
            icnt       <= '0;
          end
        end
        S_LOAD: begin
          if (beat) begin
            if (!i_ld_kind) begin
              if (icnt < IMEM_MAX) begin
                o_imem_we       <= 1'b1;
                o_inst_mem_addr <= i_ld_addr;
                o_inst_mem_data <= i_ld_data;
                icnt            <= icnt + 1'b1;
              end else begin
                o_overflow <= 1'b1;
              end
            end else if (i_ld_addr[4:0] != 5'd0) begin
              // x0 is hardwired in the core; swallow the beat silently
              o_reg_we        <= 1'b1;
              o_load_reg_addr <= i_ld_addr[4:0];
              o_load_reg_data <= i_ld_data;
            end
            if (i_ld_last) begin
              o_pc_start <= i_pc_start;
              scnt       <= '0;
            end
          end
        end
        S_SETTLE: begin
          scnt      <= scnt + 1'b1;
          run_first <= 1'b1;
        end
        S_RUN: begin
          run_first <= 1'b0;
          prev_pc   <= i_core_pc;
          hcnt      <= halt_nx;
          o_cycles  <= cyc_nx;
          if (halt_hit)    o_done    <= 1'b1;
          else if (wd_hit) o_timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_s_core_boot_seq.sv
// Bench for s_core_boot_seq: directed load/run scenarios with randomized data,
// beat gaps and PC streams, checked against a cycle-level behavioural model.
module tb_s_core_boot_seq;

  localparam int          XLEN = 32;
  localparam int          IW   = 4;
  localparam int          SC   = 2;
  localparam int          HC   = 4;
  localparam int          CW   = 4;
  localparam logic [31:0] SA   = 32'h00000004;
  localparam int          CMAX = (1 << CW) - 1;

  logic            clk, rst_n;
  logic            i_start, i_ld_valid, i_ld_kind, i_ld_last;
  logic [XLEN-1:0] i_ld_addr, i_ld_data, i_pc_start, i_core_pc;
  logic            o_ld_ready, o_core_rst_n, o_setup, o_imem_we, o_reg_we;
  logic [XLEN-1:0] o_inst_mem_addr, o_inst_mem_data, o_load_reg_data, o_pc_start;
  logic [4:0]      o_load_reg_addr;
  logic            o_done, o_timeout, o_overflow;
  logic [CW-1:0]   o_cycles;

  s_core_boot_seq #(
    .XLEN(XLEN), .IMEM_WORDS(IW), .START_ADDR(SA),
    .SETTLE_CYCLES(SC), .HALT_CYCLES(HC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready), .i_ld_kind(i_ld_kind),
    .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data), .i_ld_last(i_ld_last),
    .i_pc_start(i_pc_start), .i_core_pc(i_core_pc),
    .o_core_rst_n(o_core_rst_n), .o_setup(o_setup),
    .o_imem_we(o_imem_we), .o_inst_mem_addr(o_inst_mem_addr),
    .o_inst_mem_data(o_inst_mem_data), .o_reg_we(o_reg_we),
    .o_load_reg_addr(o_load_reg_addr), .o_load_reg_data(o_load_reg_data),
    .o_pc_start(o_pc_start), .o_done(o_done), .o_timeout(o_timeout),
    .o_overflow(o_overflow), .o_cycles(o_cycles)
  );

  typedef struct {
    logic        kind;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t       bq[$];
  int          ncmp, nerr;
  int          m_cnt;
  bit          m_ovf;
  logic [31:0] m_pcs;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset;
    chk("rst_ready",  o_ld_ready, 0);
    chk("rst_setup",  o_setup, 0);
    chk("rst_corern", o_core_rst_n, 0);
    chk("rst_imemwe", o_imem_we, 0);
    chk("rst_regwe",  o_reg_we, 0);
    chk("rst_iaddr",  o_inst_mem_addr, 0);
    chk("rst_idata",  o_inst_mem_data, 0);
    chk("rst_raddr",  o_load_reg_addr, 0);
    chk("rst_rdata",  o_load_reg_data, 0);
    chk("rst_pcs",    o_pc_start, SA);
    chk("rst_done",   o_done, 0);
    chk("rst_to",     o_timeout, 0);
    chk("rst_ovf",    o_overflow, 0);
    chk("rst_cycles", o_cycles, 0);
  endtask

  task automatic do_start;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    m_cnt = 0;
    m_ovf = 1'b0;
    chk("start_ready", o_ld_ready, 1);
    chk("start_setup", o_setup, 1);
    chk("start_done",  o_done, 0);
    chk("start_to",    o_timeout, 0);
    chk("start_ovf",   o_overflow, 0);
    chk("start_cyc",   o_cycles, 0);
  endtask

  // Drive the queued beats; gaps inserts idle cycles and random i_start pokes
  task automatic do_load(input logic [31:0] pcs, input bit gaps);
    bit last, e_i, e_r;
    int n;
    for (int i = 0; i < bq.size(); i++) begin
      last       = (i == bq.size() - 1);
      i_ld_valid = 1'b1;
      i_ld_kind  = bq[i].kind;
      i_ld_addr  = bq[i].addr;
      i_ld_data  = bq[i].data;
      i_ld_last  = last;
      i_pc_start = pcs;
      if (gaps) i_start = 1'($urandom % 2);
      chk("ld_ready", o_ld_ready, 1);
      tick;
      i_ld_valid = 1'b0;
      i_ld_last  = 1'b0;
      e_i = 0;
      e_r = 0;
      if (!bq[i].kind) begin
        if (m_cnt < IW) begin
          e_i = 1;
          m_cnt++;
          chk("imem_addr", o_inst_mem_addr, bq[i].addr);
          chk("imem_data", o_inst_mem_data, bq[i].data);
        end else m_ovf = 1'b1;
      end else if (bq[i].addr[4:0] != 5'd0) begin
        e_r = 1;
        chk("reg_addr", o_load_reg_addr, bq[i].addr[4:0]);
        chk("reg_data", o_load_reg_data, bq[i].data);
      end
      chk("imem_we",  o_imem_we, e_i);
      chk("reg_we",   o_reg_we, e_r);
      chk("overflow", o_overflow, m_ovf);
      if (gaps && !last) begin
        n = 1 + int'($urandom % 2);
        repeat (n) begin
          i_start = 1'($urandom % 2);
          tick;
          chk("gap_imem_we", o_imem_we, 0);
          chk("gap_reg_we",  o_reg_we, 0);
          chk("gap_setup",   o_setup, 1);
        end
      end
    end
    i_start = 1'b0;
    m_pcs   = pcs;
    chk("end_setup", o_setup, 0);
    chk("end_ready", o_ld_ready, 0);
    chk("end_corern", o_core_rst_n, 0);
    chk("pc_start",  o_pc_start, pcs);
    for (int k = 1; k <= SC; k++) begin
      tick;
      chk("settle_corern", o_core_rst_n, (k == SC));
    end
  endtask

  // mode 0: directed halt at 0xC, 1: always-changing PC, 2: random PC from {0,4}
  task automatic do_run(input int mode, input int abort_at);
    logic [31:0] pc, prev;
    int  streak, c, ec;
    bit  ended, e_done, e_to;
    streak = 0; c = 0; ended = 0; e_done = 0; e_to = 0; prev = '0;
    for (int i = 0; i < 40 && !ended; i++) begin
      case (mode)
        0:       pc = (i < 2) ? 32'(4 * (i + 1)) : 32'hC;
        1:       pc = 32'(32'h1000 * (i + 1)) + ($urandom & 32'hFFC);
        default: pc = 32'(4 * ($urandom % 2));
      endcase
      i_core_pc = pc;
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk_reset;
        tick;
        rst_n = 1'b1;
        tick;
        chk_reset;
        return;
      end
      tick;
      c++;
      streak = (i > 0 && pc == prev) ? streak + 1 : 1;
      prev   = pc;
      if (streak >= HC)   e_done = 1;
      else if (c >= CMAX) e_to = 1;
      ended = e_done | e_to;
      chk("run_done",   o_done, e_done);
      chk("run_to",     o_timeout, e_to);
      chk("run_cycles", o_cycles, (c > CMAX) ? CMAX : c);
      chk("run_corern", o_core_rst_n, !ended);
    end
    chk("run_ended", ended, 1);
    ec = (c > CMAX) ? CMAX : c;
    repeat (3) begin
      i_core_pc = $urandom;
      tick;
      chk("hold_cycles", o_cycles, ec);
      chk("hold_done",   o_done, e_done);
      chk("hold_to",     o_timeout, e_to);
      chk("hold_corern", o_core_rst_n, 0);
      chk("hold_pcs",    o_pc_start, m_pcs);
    end
  endtask

  function automatic beat_t mk(input logic kind, input logic [31:0] addr, input logic [31:0] data);
    beat_t b;
    b.kind = kind;
    b.addr = addr;
    b.data = data;
    return b;
  endfunction

  initial begin
    ncmp = 0; nerr = 0;
    rst_n = 1'b0; i_start = 1'b0; i_ld_valid = 1'b0; i_ld_kind = 1'b0;
    i_ld_addr = '0; i_ld_data = '0; i_ld_last = 1'b0; i_pc_start = '0; i_core_pc = '0;
    m_pcs = SA;
    repeat (2) tick;
    chk_reset;
    rst_n = 1'b1;
    tick;
    chk_reset;

    // basic program load then halt self-loop at 0xC
    do_start;
    bq.delete();
    bq.push_back(mk(1'b0, 32'h4, 32'h00120413));
    bq.push_back(mk(1'b0, 32'h8, 32'h006201B3));
    bq.push_back(mk(1'b0, 32'hC, 32'h0000006F));
    bq.push_back(mk(1'b1, 32'h4, 32'h1));
    bq.push_back(mk(1'b1, 32'h5, $urandom));
    do_load(32'h4, 1'b0);
    do_run(0, -1);

    // always-changing PC hits the watchdog
    do_start;
    bq.delete();
    bq.push_back(mk(1'b0, $urandom & 32'hFFFC, $urandom));
    bq.push_back(mk(1'b0, $urandom & 32'hFFFC, $urandom));
    do_load(32'h40, 1'b0);
    do_run(1, -1);

    // imem overflow, reg index 0, gapped beats with i_start pokes
    do_start;
    bq.delete();
    for (int i = 0; i < IW + 2; i++) bq.push_back(mk(1'b0, 32'(4 * i), $urandom));
    bq.push_back(mk(1'b1, 32'hFFFFFF00, $urandom));
    bq.push_back(mk(1'b1, 32'h1 + ($urandom % 31), $urandom));
    do_load($urandom & 32'hFFFC, 1'b1);
    do_run(2, -1);

    // async reset mid-RUN, then a clean reload
    do_start;
    bq.delete();
    bq.push_back(mk(1'b0, 32'h0, $urandom));
    bq.push_back(mk(1'b1, 32'h3, $urandom));
    do_load(32'h80, 1'b0);
    do_run(1, 5);
    m_pcs = SA;
    do_start;
    bq.delete();
    bq.push_back(mk(1'b0, 32'h10, $urandom));
    bq.push_back(mk(1'b1, 32'h7, $urandom));
    bq.push_back(mk(1'b0, 32'h14, $urandom));
    do_load(32'h10, 1'b1);
    do_run(0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
